// File: rtl/spi_jstk_master.sv
// SPI mode-0 master polling the joystick with fixed 5-byte transactions.
// Returns 10-bit X/Y positions and 3 button bits once per poll.
module spi_jstk_master #(
  parameter int HALF_PERIOD = 750,
  parameter int CS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] led_cmd,
  input  logic       miso,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [2:0] buttons
);

  localparam int M1 = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int MAXC = (M1 > BYTE_GAP) ? M1 : BYTE_GAP;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HP_END  = CW'(HALF_PERIOD);
  localparam logic [CW-1:0] CS_END  = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] GAP_END = CW'(BYTE_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, GAP, FINISH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    edges;
  logic [2:0]    byte_idx;
  logic [39:0]   tx;
  logic [39:0]   rx;
  logic [39:0]   tx_init;

  assign tx_init = {6'b100000, led_cmd, 32'h0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      edges    <= '0;
      byte_idx <= '0;
      tx       <= '0;
      rx       <= '0;
      ss       <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      x_pos    <= '0;
      y_pos    <= '0;
      buttons  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        // FINISH accepts start too, so back-to-back polls see one ss-high cycle
        IDLE, FINISH: begin
          ss   <= 1'b1;
          sclk <= 1'b0;
          mosi <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            state <= SETUP;
            ss    <= 1'b0;
            busy  <= 1'b1;
            tx    <= tx_init;
            mosi  <= tx_init[39];
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          if (cnt == CS_END) begin
            state    <= SHIFT;
            cnt      <= '0;
            edges    <= '0;
            byte_idx <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHIFT: begin
          if (cnt == HP_END) begin
            cnt   <= '0;
            sclk  <= ~sclk;
            edges <= edges + 4'd1;
            if (!sclk) begin
              rx <= {rx[38:0], miso};
            end else begin
              tx   <= {tx[38:0], 1'b0};
              mosi <= tx[38];
              if (edges == 4'd15) begin
                if (byte_idx == 3'd4) begin
                  state   <= FINISH;
                  ss      <= 1'b1;
                  mosi    <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  x_pos   <= {rx[25:24], rx[39:32]};
                  y_pos   <= {rx[9:8], rx[23:16]};
                  buttons <= rx[2:0];
                end else begin
                  state    <= GAP;
                  byte_idx <= byte_idx + 3'd1;
                end
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_END) begin
            state <= SHIFT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_jstk_master.sv
// Directed bench for spi_jstk_master with a mode-0 joystick slave model.
// Small parameters keep each poll at 340 cycles.
module tb_spi_jstk_master;

  localparam int HP = 3;
  localparam int CS = 4;
  localparam int BG = 4;
  localparam int LAT = CS + 80 * (HP + 1) + 4 * BG;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] led_cmd = 2'b00;
  logic       miso;
  logic       ss, sclk, mosi, busy, done;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;

  spi_jstk_master #(
    .HALF_PERIOD(HP),
    .CS_SETUP(CS),
    .BYTE_GAP(BG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .led_cmd(led_cmd),
    .miso(miso),
    .ss(ss),
    .sclk(sclk),
    .mosi(mosi),
    .busy(busy),
    .done(done),
    .x_pos(x_pos),
    .y_pos(y_pos),
    .buttons(buttons)
  );

  always #5 clk = ~clk;

  // Slave: MISO shifts on falling SCLK, MOSI captured on rising SCLK
  logic [39:0] slv_data = '0;
  logic [63:0] cap = '0;
  int fall_cnt = 0;
  int fall_base = 0;
  int idx;
  logic [5:0] bi;

  assign idx = fall_cnt - fall_base;
  assign bi = 6'(39 - idx);
  assign miso = (ss || idx > 39) ? 1'b0 : slv_data[bi];

  always @(negedge sclk) fall_cnt++;
  always @(negedge ss) fall_base = fall_cnt;
  always @(posedge sclk) cap = {cap[62:0], mosi};

  // Cycle monitor sampling at the falling clock edge
  int cyc = 0, rises = 0, dones = 0;
  int t_ssf = 0, t_first = 0, t_lat = 0;
  int hi_run = 0, lo_run = 0, hi4 = 0, hi_bad = 0;
  int lo4 = 0, lo8 = 0, lo_bad = 0;
  int mosi_bad = 0, done_wide = 0;
  int ss_hi_run = 0, ss_hi_last = 0;
  bit got_rise = 0;
  logic p_ss = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_done = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!ss && p_ss) begin
      t_ssf = cyc;
      got_rise = 0;
      ss_hi_last = ss_hi_run;
      ss_hi_run = 0;
      lo_run = 0;
      hi_run = 0;
    end
    if (ss) ss_hi_run++;
    if (sclk && !p_sclk) begin
      rises++;
      if (!got_rise) t_first = cyc - t_ssf;
      else if (lo_run == 4) lo4++;
      else if (lo_run == 8) lo8++;
      else lo_bad++;
      got_rise = 1;
      if (mosi !== p_mosi) mosi_bad++;
      lo_run = 0;
    end
    if (!sclk && p_sclk) begin
      if (hi_run == 4) hi4++;
      else hi_bad++;
      hi_run = 0;
    end
    if (sclk) hi_run++;
    else if (!ss) lo_run++;
    if (done) begin
      dones++;
      t_lat = cyc - t_ssf;
      if (p_done) done_wide++;
    end
    p_ss = ss;
    p_sclk = sclk;
    p_mosi = mosi;
    p_done = done;
  end

  int total = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int tgt, input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (dones >= tgt) break;
      step();
    end
    check(tag, 64'(dones >= tgt), 64'd1);
  endtask

  int d0, r0;

  initial begin
    steps(3);
    check("rst_ss", 64'(ss), 64'd1);
    check("rst_sclk", 64'(sclk), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out", {34'd0, x_pos, y_pos, buttons}, 64'd0);
    rst_n = 1'b1;
    steps(3);
    check("idle_ss", 64'(ss), 64'd1);

    // Poll 1
    slv_data = 40'h2A_03_55_01_05;
    led_cmd = 2'b10;
    pulse_start();
    check("p1_ss_low", 64'(ss), 64'd0);
    check("p1_busy", 64'(busy), 64'd1);
    check("p1_mosi0", 64'(mosi), 64'd1);
    wait_done(1, "p1_done_seen");
    check("p1_latency", 64'(t_lat), 64'(LAT));
    check("p1_x", 64'(x_pos), 64'h32A);
    check("p1_y", 64'(y_pos), 64'h155);
    check("p1_btn", 64'(buttons), 64'h5);
    check("p1_busy_fin", 64'(busy), 64'd0);
    check("p1_ss_fin", 64'(ss), 64'd1);
    check("p1_rises", 64'(rises), 64'd40);
    check("p1_mosi_bytes", 64'(cap[39:0]), 64'h82_00_00_00_00);
    check("p1_mosi_stable", 64'(mosi_bad), 64'd0);
    check("p1_first_rise", 64'(t_first), 64'(CS + HP + 1));
    check("p1_high_4", 64'(hi4), 64'd40);
    check("p1_high_bad", 64'(hi_bad), 64'd0);
    check("p1_low_4", 64'(lo4), 64'd35);
    check("p1_gap_low_8", 64'(lo8), 64'd4);
    check("p1_low_bad", 64'(lo_bad), 64'd0);
    step();
    check("p1_done_pulse", 64'(done), 64'd0);

    // Poll 2 with start pulsed while busy
    slv_data = 40'hFF_FF_00_00_00;
    led_cmd = 2'b00;
    d0 = dones;
    r0 = rises;
    pulse_start();
    steps(100);
    pulse_start();
    steps(100);
    check("p2_hold_x", 64'(x_pos), 64'h32A);
    check("p2_hold_btn", 64'(buttons), 64'h5);
    wait_done(d0 + 1, "p2_done_seen");
    check("p2_x", 64'(x_pos), 64'h3FF);
    check("p2_y", 64'(y_pos), 64'h0);
    check("p2_btn", 64'(buttons), 64'h0);
    check("p2_mosi_bytes", 64'(cap[39:0]), 64'h80_00_00_00_00);
    steps(400);
    check("p2_one_done", 64'(dones - d0), 64'd1);
    check("p2_rises", 64'(rises - r0), 64'd40);
    check("p2_idle_ss", 64'(ss), 64'd1);
    check("done_width", 64'(done_wide), 64'd0);

    // start held high: back-to-back polls
    slv_data = 40'h2A_03_55_01_05;
    d0 = dones;
    start = 1'b1;
    wait_done(d0 + 1, "b2b_done1");
    for (int i = 0; i < 10 && ss; i++) step();
    check("b2b_restart", 64'(ss), 64'd0);
    check("b2b_ss_high", 64'(ss_hi_last), 64'd1);
    start = 1'b0;
    wait_done(d0 + 2, "b2b_done2");
    steps(50);
    check("b2b_stop", 64'(dones - d0), 64'd2);

    // Asynchronous reset in the middle of SHIFT
    pulse_start();
    steps(100);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ss", 64'(ss), 64'd1);
    check("ar_sclk", 64'(sclk), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_out", {34'd0, x_pos, y_pos, buttons}, 64'd0);
    steps(2);
    rst_n = 1'b1;
    d0 = dones;
    steps(30);
    check("ar_idle_ss", 64'(ss), 64'd1);
    check("ar_no_done", 64'(dones - d0), 64'd0);
    slv_data = 40'h11_02_22_03_06;
    pulse_start();
    wait_done(d0 + 1, "ar_poll_done");
    check("ar_poll_x", 64'(x_pos), 64'h211);
    check("ar_poll_y", 64'(y_pos), 64'h322);
    check("ar_poll_btn", 64'(buttons), 64'h6);
    check("ar_poll_lat", 64'(t_lat), 64'(LAT));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
